// File: rtl/lcd_timing_gen_param.sv
// Parametrised LCD timing generator with framebuffer read-out.
// Sync/DE/RGB share one RD_LAT+2 tick latency from the stage-0 counters to the pins.
module lcd_timing_gen_param #(
   parameter int H_SYNC = 41,
   parameter int H_BP   = 2,
   parameter int H_ACT  = 480,
   parameter int H_FP   = 2,
   parameter int V_SYNC = 10,
   parameter int V_BP   = 2,
   parameter int V_ACT  = 272,
   parameter int V_FP   = 1,
   parameter int HS_POL = 1,
   parameter int VS_POL = 1,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = 17
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEnClk,
   input  logic              iMode,
   input  logic [ADDR_W-1:0] iBaseAddr,
   input  logic              iBlank,
   input  logic [15:0]       iRamRdData,
   output logic [ADDR_W-1:0] oRamRdAddr,
   output logic              oLcdHSync,
   output logic              oLcdVSync,
   output logic              oLcdDe,
   output logic [4:0]        oLcdR,
   output logic [5:0]        oLcdG,
   output logic [4:0]        oLcdB,
   output logic              oFrameStart
);

   localparam logic [11:0] H_TOT  = 12'(H_SYNC + H_BP + H_ACT + H_FP);
   localparam logic [11:0] V_TOT  = 12'(V_SYNC + V_BP + V_ACT + V_FP);
   localparam logic [11:0] H_SE   = 12'(H_SYNC);
   localparam logic [11:0] V_SE   = 12'(V_SYNC);
   localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BP + H_ACT);
   localparam logic [11:0] V_A0   = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_A1   = 12'(V_SYNC + V_BP + V_ACT);
   localparam logic        HS_ON  = 1'(HS_POL);
   localparam logic        VS_ON  = 1'(VS_POL);

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic bsel;
      logic blank;
      logic mode;
   } side_t;

   logic [11:0]       h_q, h_d, v_q, v_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
   side_t [RD_LAT:0]  side_q, side_d;
   logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic [4:0]        r_q, r_d, b_q, b_d;
   logic [5:0]        g_q, g_d;

   logic              fs, mode_cur, act0;
   logic [ADDR_W-1:0] ptr_cur;
   side_t             s0, sl;
   logic [7:0]        gray;

   always_comb begin
      fs       = iEnClk && !iRst && (h_q == 12'd0) && (v_q == 12'd0);
      // Frame-start tick uses the fresh mode/base so the very first pixel is correct.
      mode_cur = fs ? iMode : mode_q;
      ptr_cur  = fs ? iBaseAddr : ptr_q;
      act0     = (h_q >= H_A0) && (h_q < H_A1) && (v_q >= V_A0) && (v_q < V_A1);

      s0.hs    = h_q < H_SE;
      s0.vs    = v_q < V_SE;
      s0.act   = act0;
      s0.bsel  = h_q[0] ^ H_A0[0];
      s0.blank = iBlank;
      s0.mode  = mode_cur;

      sl   = side_q[RD_LAT];
      gray = sl.bsel ? iRamRdData[15:8] : iRamRdData[7:0];

      h_d    = h_q;
      v_d    = v_q;
      mode_d = mode_q;
      ptr_d  = ptr_q;
      addr_d = addr_q;
      side_d = side_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      de_d   = de_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;

      if (iEnClk) begin
         if (h_q == H_TOT - 12'd1) begin
            h_d = 12'd0;
            v_d = (v_q == V_TOT - 12'd1) ? 12'd0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
         end

         mode_d = mode_cur;
         ptr_d  = ptr_cur;
         if (act0) begin
            addr_d = ptr_cur;
            if (!mode_cur || s0.bsel) ptr_d = ptr_cur + ADDR_W'(1);
         end

         side_d[0] = s0;
         for (int i = 1; i <= RD_LAT; i++) side_d[i] = side_q[i-1];

         hs_d = sl.hs ? HS_ON : ~HS_ON;
         vs_d = sl.vs ? VS_ON : ~VS_ON;
         de_d = sl.act;
         r_d  = 5'd0;
         g_d  = 6'd0;
         b_d  = 5'd0;
         if (sl.act && !sl.blank) begin
            if (sl.mode) begin
               r_d = gray[7:3];
               g_d = gray[7:2];
               b_d = gray[7:3];
            end else begin
               r_d = iRamRdData[15:11];
               g_d = iRamRdData[10:5];
               b_d = iRamRdData[4:0];
            end
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         h_q    <= 12'd0;
         v_q    <= 12'd0;
         mode_q <= 1'b0;
         ptr_q  <= '0;
         addr_q <= '0;
         side_q <= '0;
         hs_q   <= ~HS_ON;
         vs_q   <= ~VS_ON;
         de_q   <= 1'b0;
         r_q    <= 5'd0;
         g_q    <= 6'd0;
         b_q    <= 5'd0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         mode_q <= mode_d;
         ptr_q  <= ptr_d;
         addr_q <= addr_d;
         side_q <= side_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         de_q   <= de_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
      end
   end

   assign oRamRdAddr  = addr_q;
   assign oLcdHSync   = hs_q;
   assign oLcdVSync   = vs_q;
   assign oLcdDe      = de_q;
   assign oLcdR       = r_q;
   assign oLcdG       = g_q;
   assign oLcdB       = b_q;
   assign oFrameStart = fs;

endmodule

// File: tb/tb_lcd_timing_gen_param.sv
// Scoreboard bench for lcd_timing_gen_param on a small 8x6 raster with a 1-tick RAM.
// Expected pins are derived from tick index arithmetic, not from counters.
module tb_lcd_timing_gen_param;

   localparam int H_SYNC = 2, H_BP = 1, H_ACT = 4, H_FP = 1;
   localparam int V_SYNC = 1, V_BP = 1, V_ACT = 3, V_FP = 1;
   localparam int HS_POL = 1, VS_POL = 1, RD_LAT = 1, ADDR_W = 17;
   localparam int HT  = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int VT  = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int FR  = HT * VT;
   localparam int HA0 = H_SYNC + H_BP;
   localparam int VA0 = V_SYNC + V_BP;
   localparam bit HS_ON = (HS_POL != 0);
   localparam bit VS_ON = (VS_POL != 0);

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } pix_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1, en = 1'b1, mode = 1'b0, blank = 1'b0;
   logic [ADDR_W-1:0] base = 17'h10;
   logic [15:0]       rd_data;
   logic [ADDR_W-1:0] addr_o;
   logic              hs_o, vs_o, de_o, fs_o;
   logic [4:0]        r_o, b_o;
   logic [5:0]        g_o;

   lcd_timing_gen_param #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
   ) dut (
      .iClk(clk), .iRst(rst), .iEnClk(en), .iMode(mode), .iBaseAddr(base),
      .iBlank(blank), .iRamRdData(rd_data), .oRamRdAddr(addr_o),
      .oLcdHSync(hs_o), .oLcdVSync(vs_o), .oLcdDe(de_o),
      .oLcdR(r_o), .oLcdG(g_o), .oLcdB(b_o), .oFrameStart(fs_o)
   );

   always #5 clk = ~clk;

   // Word at the default base is the GRAY8 test pattern; elsewhere data tracks the address.
   function automatic logic [15:0] ram_word(input logic [ADDR_W-1:0] a);
      if (a == 17'h10) return 16'hA05F;
      return a[15:0] ^ {15'h0, a[16]};
   endfunction

   logic [15:0] ram_pipe [RD_LAT];
   initial for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = 16'h0;
   always @(posedge clk) begin
      if (en) begin
         ram_pipe[0] <= ram_word(addr_o);
         for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
      end
   end
   assign rd_data = ram_pipe[RD_LAT-1];

   function automatic pix_t rst_pix();
      pix_t p;
      p    = '0;
      p.hs = !HS_ON;
      p.vs = !VS_ON;
      return p;
   endfunction

   function automatic pix_t mk_pix(input bit act, input bit hsa, input bit vsa, input bit blk,
                                   input bit md, input bit hi, input logic [15:0] d);
      pix_t p;
      logic [7:0] gy;
      p    = '0;
      p.de = act;
      p.hs = hsa ? HS_ON : !HS_ON;
      p.vs = vsa ? VS_ON : !VS_ON;
      gy   = hi ? d[15:8] : d[7:0];
      if (act && !blk) begin
         if (md) begin
            p.r = gy[7:3]; p.g = gy[7:2]; p.b = gy[7:3];
         end else begin
            p.r = d[15:11]; p.g = d[10:5]; p.b = d[4:0];
         end
      end
      return p;
   endfunction

   // Reference model state: t counts enabled ticks since reset release.
   int                t = 0;
   int                kind = 0;   // 0 none yet, 1 reset edge, 2 enabled edge, 3 held edge
   bit                lat_mode = 1'b0;
   logic [ADDR_W-1:0] lat_base = '0, addr_m = '0;
   pix_t              pq[$];
   logic [ADDR_W-1:0] aq[$];
   int                total = 0, bad = 0;

   task automatic model_edge();
      int h, v, px, p;
      bit act;
      logic [15:0] d;
      if (rst) begin
         kind = 1;
         t = 0;
         addr_m = '0;
         pq.delete();
         aq.delete();
         for (int i = 0; i <= RD_LAT; i++) pq.push_back(rst_pix());
      end else if (!en) begin
         kind = 3;
      end else begin
         kind = 2;
         h = t % HT;
         v = (t / HT) % VT;
         if (t % FR == 0) begin
            lat_mode = mode;
            lat_base = base;
         end
         act = (h >= HA0) && (h < HA0 + H_ACT) && (v >= VA0) && (v < VA0 + V_ACT);
         px  = h - HA0;
         d   = 16'h0;
         if (act) begin
            p = (v - VA0) * H_ACT + px;
            addr_m = lat_base + ADDR_W'(lat_mode ? p / 2 : p);
            d = ram_word(addr_m);
         end
         aq.push_back(addr_m);
         pq.push_back(mk_pix(act, h < H_SYNC, v < V_SYNC, blank, lat_mode, px[0], d));
         t++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_pix(input string nm, input pix_t got, input pix_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0d: got de/hs/vs=%0b%0b%0b rgb=%h/%h/%h, need de/hs/vs=%0b%0b%0b rgb=%h/%h/%h",
                  nm, t, got.de, got.hs, got.vs, got.r, got.g, got.b,
                  exp.de, exp.hs, exp.vs, exp.r, exp.g, exp.b);
      end
   endtask

   task automatic chk_addr(input string nm, input logic [ADDR_W-1:0] got, input logic [ADDR_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0d: got addr=%h, need %h", nm, t, got, exp);
      end
   endtask

   pix_t              last_pix;
   logic [ADDR_W-1:0] last_addr;

   always @(negedge clk) begin
      pix_t got, ep;
      logic [ADDR_W-1:0] ea;
      bit efs;
      got = {de_o, hs_o, vs_o, r_o, g_o, b_o};
      if (kind == 1) begin
         chk_pix("reset_pins", got, rst_pix());
         chk_addr("reset_addr", addr_o, '0);
         last_pix  = rst_pix();
         last_addr = '0;
      end else if (kind == 2) begin
         if (pq.size() == 0 || aq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue_underflow t=%0d: got empty, need entry", t);
         end else begin
            ep = pq.pop_front();
            ea = aq.pop_front();
            chk_pix("pixel", got, ep);
            chk_addr("addr", addr_o, ea);
            last_pix  = ep;
            last_addr = ea;
         end
      end else if (kind == 3) begin
         chk_pix("hold_pins", got, last_pix);
         chk_addr("hold_addr", addr_o, last_addr);
      end
      if (kind != 0) begin
         efs = en && !rst && (t % FR == 0);
         total++;
         if (fs_o !== efs) begin
            bad++;
            $display("FAIL frame_start t=%0d: got %0b, need %0b", t, fs_o, efs);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b0; blank = 1'b0; base = 17'h10;
      repeat (3) step();
      rst = 1'b0;
      // RGB565 from base 0x10, continuous enable
      repeat (2 * FR) step();
      // GRAY8 requested mid-frame: must wait for the next frame start
      repeat (FR / 2) step();
      mode = 1'b1;
      repeat (2 * FR) step();
      // alternating enable, blank on one raster line
      for (int i = 0; i < 4 * FR; i++) begin
         step();
         en = !en;
         blank = (((t / HT) % VT) == VA0 + 1);
      end
      en = 1'b1;
      blank = 1'b0;
      // random traffic with occasional resets and base values near the wrap point
      for (int i = 0; i < 2000; i++) begin
         step();
         rst   = ($urandom_range(0, 199) == 0);
         en    = ($urandom_range(0, 3) != 0);
         blank = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1);
         if ($urandom_range(0, 31) == 0)
            base = ($urandom_range(0, 1) == 1) ? ADDR_W'(17'h1FFFA) : ADDR_W'($urandom);
      end
      rst = 1'b0;
      repeat (FR) step();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
